// File: rtl/dmem_pkg.sv
// Shared types, constants and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DEPTH_DEF = 1024;
  localparam logic [31:0] BASE_DEF  = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Pull the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sign);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] res;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (size)
      SZ_BYTE: res = {{24{sign & sh_b[7]}}, sh_b[7:0]};
      SZ_HALF: res = {{16{sign & sh_h[15]}}, sh_h[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of a word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'h0, wdata[7:0]} << {lane, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'h0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous read-first, full-word write, no reset.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for CPU loads/stores: handshake, address checks,
// lane extraction and read-modify-write for sub-word stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter logic [31:0] BASE  = BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state, state_d;
  logic          ready_d, resp_valid_d, resp_err_d;
  logic [31:0]   resp_rdata_d;

  logic          we_q, sign_q;
  logic [1:0]    size_q, lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wr_word_q, wr_word_d;
  logic          cap;

  logic [31:0]   off_c;
  logic          err_c, accept_c;

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  // Request decode; the subtraction is only meaningful when addr >= BASE.
  always_comb begin
    off_c    = req_addr - BASE;
    accept_c = req_valid && (state == ST_IDLE);
    err_c    = (req_addr < BASE)
            || ({2'b00, off_c[31:2]} >= 32'(DEPTH))
            || (req_size == 2'b11)
            || ((req_size == SZ_HALF) && off_c[0])
            || ((req_size == SZ_WORD) && (off_c[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    cap          = 1'b0;
    wr_word_d    = wr_word_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = idx_q;
    ram_wdata    = wr_word_q;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          cap       = 1'b1;
          wr_word_d = req_wdata;
          if (err_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            ram_addr = off_c[AW+1:2];
            // Loads and sub-word stores both need the current word first.
            if (!req_we || (req_size != SZ_WORD)) begin
              ram_en  = 1'b1;
              state_d = ST_RD;
            end else begin
              state_d = ST_WR;
            end
          end
        end
      end
      ST_RD: begin
        if (!we_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_extract(ram_rdata, size_q, lane_q, sign_q);
        end else begin
          wr_word_d = lane_merge(ram_rdata, wr_word_q, size_q, lane_q);
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      req_ready  <= ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

  // Captured request fields used after the acceptance edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      idx_q     <= '0;
      wr_word_q <= 32'h0;
    end else begin
      wr_word_q <= wr_word_d;
      if (cap) begin
        we_q   <= req_we;
        sign_q <= req_sign;
        size_q <= req_size;
        lane_q <= off_c[1:0];
        idx_q  <= off_c[AW+1:2];
      end
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for CPU data accesses.
- Accepts one load/store request at a time over a valid/ready handshake and maps the Mars data-segment address (base 0x1001_0000) to a word index.
- Performs byte, halfword and word accesses with little-endian lane selection; sub-word stores use read-modify-write.
- Replaces the single-cycle word-only data memory path so the CPU can stall on `req_ready`/`resp_valid`.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data array.
- BASE, 32'h1001_0000, Mars address of word 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  Mars byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; access rejected.

Behaviour:
- Reset (rst low, async): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Array contents are not cleared.
  - A reset during RD or WR aborts the access: no array write occurs unless the WR edge has already happened.
- Handshake:
  - Accept on a rising edge with req_valid && req_ready.
  - req_ready = (state==IDLE); requests are captured into internal registers at acceptance.
  - No backpressure on the response: resp_valid is high for exactly one cycle (state RESP).
- Address checks, combinational at acceptance:
  - off = req_addr - BASE; idx = off[31:2]; lane = off[1:0].
  - err if req_addr < BASE, or idx >= DEPTH, or req_size==11, or (half and lane[0]!=0), or (word and lane!=0).
- FSM states: IDLE, RD, WR, RESP.
  - IDLE, accept with err -> RESP with resp_err=1; no array access.
  - IDLE, accept load -> RD (sync array read issued) -> RESP.
  - IDLE, accept word store -> WR.
  - IDLE, accept byte/half store -> RD -> WR.
  - RD -> RESP for loads; RD -> WR for sub-word stores, with the read word latched as merge source.
  - WR: write the merged word on the WR edge -> RESP.
  - RESP -> IDLE.
- Latency, with acceptance edge = E0:
  - error response: resp_valid in the cycle after E0.
  - load and word store: response after E1.
  - sub-word store: response after E2.
  - Back-to-back: the next request is acceptable on the edge after RESP, giving a minimum 1-cycle bubble between responses.
- Load extraction:
  - byte = word[8*lane +: 8]; half = word[16*lane[1] +: 16].
  - Extend per req_sign; word loads ignore req_sign.
- Store merge:
  - byte replaces bits [8*lane +: 8] with wdata[7:0].
  - half replaces [16*lane[1] +: 16] with wdata[15:0].
  - Other bytes are preserved.
- Read-after-write: a load accepted immediately after a store response returns the new data (the write completes before RESP).
- Address wrap: req_addr near 32'hFFFF_FFFF never wraps into range; the out-of-range check uses unsigned compare on the full 32 bits.

Decomposition:
- Shared package `dmem_pkg`:
  - state enum (IDLE/RD/WR/RESP).
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - BASE default constant.
  - lane-extract and lane-merge functions.
- One sub-module `dmem_ram`: single-port, DEPTH x 32, synchronous read, full-word write enable, no reset. The FSM, checks and merge live in `dmem_responder`.

Test Plan:
- sw 0x11223344 @0x1001_0004, then lw @0x1001_0004 -> store resp after 2 edges, err=0; load resp_rdata=0x11223344, 2 edges after accept.
- sb 0x000000AB @0x1001_0005 over word 0x11223344 -> 3-edge store latency; subsequent lw @0x1001_0004 = 0x1122AB44.
- lb signed @0x1001_0005 -> 0xFFFFFFAB; lbu -> 0x000000AB; lh signed @0x1001_0006 -> 0x00001122; sh 0x8000 @0x1001_0006 then lh signed -> 0xFFFF8000.
- lw @0x1001_0002, sh @0x1001_0001, size=11, addr 0x0FFF_FFFC, addr BASE+4*DEPTH -> each gives resp_err=1, rdata=0, resp 1 edge after accept; array unchanged.
- sb accepted, rst pulled low during RD -> outputs immediately at reset values, req_ready=1; target word unchanged on later lw.
- req_valid held high with 3 consecutive lw -> req_ready low during RD/RESP; exactly 3 resp_valid pulses, each 1 cycle, in request order.
